decode_exec_skid_reg: RTL and testbench

Parametrised decode-to-execute pipeline register for the vector CPU, successor to the fixed 16-lane, 16-bit decode stage register. Carries the two vector read operands, the extended immediate vector, source register addresses and execute/memory/writeback control across the stage boundary. It adds a valid/ready handshake with a one-entry skid buffer, which gives full throughput under back-pressure. It also adds a synchronous flush for branch/hazard squash and valid-gated control outputs, so bubbles never write.

---
 rtl/decode_exec_skid_reg_pkg.sv | 17 +
 rtl/decode_exec_skid_reg_if.sv | 26 ++
 rtl/decode_exec_skid_reg_slot.sv | 14 +
 rtl/decode_exec_skid_reg.sv | 59 +++++
 tb/tb_decode_exec_skid_reg.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/decode_exec_skid_reg_pkg.sv
// cpu_pipe_pkg: shared decode/execute control types and default vector geometry
package cpu_pipe_pkg;
  localparam int DEF_LANES = 16;
  localparam int DEF_N = 16;
  localparam int DEF_RA_W = 4;
  localparam logic [1:0] ALUSRC_REG = 2'b00;
  localparam logic [1:0] ALUSRC_EXT = 2'b01;
  localparam logic [1:0] ALUSRC_ZERO = 2'b10;
  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic MemWrite;
    logic [1:0] ALUSrc;
    logic [2:0] ALUControl;
    logic [DEF_RA_W-1:0] WA3;
  } id_ex_ctrl_t;
endpackage

// File: rtl/decode_exec_skid_reg_if.sv
// decode_exec_skid_reg_if: decode-side and execute-side bundle of the decode/execute stage
interface decode_exec_skid_reg_if #(
  parameter int LANES = 16,
  parameter int N = 16,
  parameter int RA_W = 4
);
  logic flush;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [LANES-1:0][N-1:0] rd1, rd2, extend, rd1o, rd2o, extendO;
  logic [RA_W-1:0] ra1, ra2, WA3, ra1o, ra2o, WA3O;
  logic RegWrite, MemtoReg, MemWrite, RegWriteO, MemtoRegO, MemWriteO;
  logic [1:0] ALUSrc, ALUSrcO;
  logic [2:0] ALUControl, ALUControlO;
  modport master (
    output flush, in_valid, out_ready, rd1, rd2, extend, ra1, ra2, WA3,
           RegWrite, MemtoReg, MemWrite, ALUSrc, ALUControl,
    input  in_ready, out_valid, rd1o, rd2o, extendO, ra1o, ra2o, WA3O,
           RegWriteO, MemtoRegO, MemWriteO, ALUSrcO, ALUControlO
  );
  modport slave (
    input  flush, in_valid, out_ready, rd1, rd2, extend, ra1, ra2, WA3,
           RegWrite, MemtoReg, MemWrite, ALUSrc, ALUControl,
    output in_ready, out_valid, rd1o, rd2o, extendO, ra1o, ra2o, WA3O,
           RegWriteO, MemtoRegO, MemWriteO, ALUSrcO, ALUControlO
  );
endinterface

// File: rtl/decode_exec_skid_reg_slot.sv
// pipe_slot: payload register with load enable and async clear
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q_o <= '0;
    else if (load_i) q_o <= d_i;
endmodule

// File: rtl/decode_exec_skid_reg.sv
// decode_exec_skid_reg: decode-to-execute register with one-entry skid buffer and flush
module decode_exec_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int N = DEF_N,
  parameter int RA_W = DEF_RA_W
) (
  input logic clk,
  input logic reset,
  decode_exec_skid_reg_if.slave bus
);
  localparam int VW = LANES * N;
  localparam int PW = 3 * VW + 2 * RA_W + $bits(id_ex_ctrl_t);
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic accept, drain, main_load, skid_load;
  logic [PW-1:0] in_pl, skid_pl, main_pl, main_src;
  id_ex_ctrl_t in_ctrl, out_ctrl;
  assign in_ctrl.RegWrite = bus.RegWrite;
  assign in_ctrl.MemtoReg = bus.MemtoReg;
  assign in_ctrl.MemWrite = bus.MemWrite;
  assign in_ctrl.ALUSrc = bus.ALUSrc;
  assign in_ctrl.ALUControl = bus.ALUControl;
  assign in_ctrl.WA3 = bus.WA3;
  assign in_pl = {bus.rd1, bus.rd2, bus.extend, bus.ra1, bus.ra2, in_ctrl};
  assign accept = bus.in_valid & ~skid_valid_q & ~bus.flush;
  assign drain = main_valid_q & bus.out_ready;
  // skid can only be full while in_ready is low, so it never races a new accept into main
  assign main_load = ~bus.flush & (skid_valid_q ? drain : accept & (~main_valid_q | drain));
  assign skid_load = accept & main_valid_q & ~drain;
  assign main_src = skid_valid_q ? skid_pl : in_pl;
  always_comb begin
    main_valid_d = bus.flush ? 1'b0 : (main_valid_q & ~drain) | skid_valid_q | accept;
    skid_valid_d = bus.flush ? 1'b0 : skid_valid_q ? ~drain : skid_load;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  pipe_slot #(.W(PW)) u_main (
    .clk(clk), .reset(reset), .load_i(main_load), .d_i(main_src), .q_o(main_pl)
  );
  pipe_slot #(.W(PW)) u_skid (
    .clk(clk), .reset(reset), .load_i(skid_load), .d_i(in_pl), .q_o(skid_pl)
  );
  assign {bus.rd1o, bus.rd2o, bus.extendO, bus.ra1o, bus.ra2o, out_ctrl} = main_pl;
  assign bus.out_valid = main_valid_q;
  assign bus.in_ready = ~skid_valid_q;
  assign bus.RegWriteO = out_ctrl.RegWrite & main_valid_q;
  assign bus.MemWriteO = out_ctrl.MemWrite & main_valid_q;
  assign bus.MemtoRegO = out_ctrl.MemtoReg;
  assign bus.ALUSrcO = out_ctrl.ALUSrc;
  assign bus.ALUControlO = out_ctrl.ALUControl;
  assign bus.WA3O = out_ctrl.WA3;
endmodule

// File: tb/tb_decode_exec_skid_reg.sv
// tb_decode_exec_skid_reg: vector table plus queue scoreboard for the skid pipeline register
module tb_decode_exec_skid_reg;
  localparam int L = 16, N = 16, R = 4;
  typedef struct packed {
    logic [L-1:0][N-1:0] rd1, rd2, ext;
    logic [R-1:0] ra1, ra2, wa3;
    logic rw, m2r, mw;
    logic [1:0] src;
    logic [2:0] alu;
  } pl_t;
  typedef struct {
    logic iv, ordy, fl, ov, ir;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  pl_t q[$];
  pl_t last = '0;
  vec_t tbl[11];
  decode_exec_skid_reg_if #(.LANES(L), .N(N), .RA_W(R)) bus ();
  decode_exec_skid_reg #(.LANES(L), .N(N), .RA_W(R)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic pl_t rnd();
    pl_t p;
    for (int i = 0; i < L; i++) begin
      p.rd1[i] = N'($urandom);
      p.rd2[i] = N'($urandom);
      p.ext[i] = N'($urandom);
    end
    {p.ra1, p.ra2, p.wa3, p.rw, p.m2r, p.mw, p.src, p.alu} = 20'($urandom);
    return p;
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic fl, input pl_t p);
    bus.in_valid = iv;
    bus.out_ready = ordy;
    bus.flush = fl;
    bus.rd1 = p.rd1;
    bus.rd2 = p.rd2;
    bus.extend = p.ext;
    bus.ra1 = p.ra1;
    bus.ra2 = p.ra2;
    bus.WA3 = p.wa3;
    bus.RegWrite = p.rw;
    bus.MemtoReg = p.m2r;
    bus.MemWrite = p.mw;
    bus.ALUSrc = p.src;
    bus.ALUControl = p.alu;
  endtask

  task automatic sample();
    logic ev;
    pl_t e;
    ev = q.size() > 0;
    if (ev) last = q[0];
    e = last;
    chk("out_valid", bus.out_valid, ev);
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("rd1o", bus.rd1o, e.rd1);
    chk("rd2o", bus.rd2o, e.rd2);
    chk("extendO", bus.extendO, e.ext);
    chk("ra_wa", {bus.ra1o, bus.ra2o, bus.WA3O}, {e.ra1, e.ra2, e.wa3});
    chk("RegWriteO", bus.RegWriteO, e.rw & ev);
    chk("MemWriteO", bus.MemWriteO, e.mw & ev);
    chk("ctrl", {bus.MemtoRegO, bus.ALUSrcO, bus.ALUControlO}, {e.m2r, e.src, e.alu});
  endtask

  // called just after a rising edge; samples mid-cycle, then advances the model at the next edge
  task automatic cycle(input logic iv, input logic ordy, input logic fl, input pl_t p,
                       input bit has_exp, input logic eov, input logic eir);
    logic rdy;
    drive(iv, ordy, fl, p);
    @(negedge clk);
    sample();
    if (has_exp) begin
      chk("tbl_out_valid", bus.out_valid, eov);
      chk("tbl_in_ready", bus.in_ready, eir);
    end
    @(posedge clk);
    rdy = q.size() < 2;
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (iv && rdy) q.push_back(p);
    end
    #1;
  endtask

  initial begin
    pl_t p;
    tbl[0]  = '{1, 1, 0, 0, 1};
    tbl[1]  = '{1, 1, 0, 1, 1};
    tbl[2]  = '{1, 0, 0, 1, 1};
    tbl[3]  = '{1, 0, 0, 1, 0};
    tbl[4]  = '{0, 1, 0, 1, 0};
    tbl[5]  = '{1, 0, 0, 1, 1};
    tbl[6]  = '{1, 0, 1, 1, 0};
    tbl[7]  = '{1, 1, 1, 0, 1};
    tbl[8]  = '{1, 0, 0, 0, 1};
    tbl[9]  = '{0, 1, 0, 1, 1};
    tbl[10] = '{0, 1, 0, 0, 1};
    drive(1, 1, 0, rnd());
    @(negedge clk);
    sample();
    drive(1, 0, 0, rnd());
    @(negedge clk);
    sample();
    drive(0, 0, 0, rnd());
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    p = rnd();
    p.rd1[0] = 16'h1234;
    cycle(1, 0, 0, p, 0, 0, 0);
    chk("rd1o_lane0", bus.rd1o[0], 16'h1234);
    chk("first_out_valid", bus.out_valid, 1'b1);
    cycle(0, 1, 0, rnd(), 0, 0, 0);
    cycle(0, 1, 0, rnd(), 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      p = rnd();
      p.alu = 3'(i);
      cycle(1, 1, 0, p, 0, 0, 0);
    end
    cycle(0, 1, 0, rnd(), 0, 0, 0);
    cycle(0, 1, 0, rnd(), 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      p = rnd();
      p.rw = 1'b1;
      cycle(tbl[i].iv, tbl[i].ordy, tbl[i].fl, p, 1, tbl[i].ov, tbl[i].ir);
    end
    p = rnd();
    p.mw = 1'b1;
    p.m2r = 1'b1;
    cycle(1, 1, 0, p, 0, 0, 0);
    cycle(0, 1, 0, rnd(), 0, 0, 0);
    cycle(0, 1, 0, rnd(), 0, 0, 0);
    chk("bubble_MemWriteO", bus.MemWriteO, 1'b0);
    chk("bubble_MemtoRegO", bus.MemtoRegO, 1'b1);
    chk("bubble_WA3O", bus.WA3O, p.wa3);
    cycle(1, 0, 0, rnd(), 0, 0, 0);
    cycle(1, 0, 0, rnd(), 0, 0, 0);
    cycle(1, 0, 0, rnd(), 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", bus.out_valid, 1'b0);
    chk("async_in_ready", bus.in_ready, 1'b1);
    q.delete();
    last = '0;
    drive(0, 1, 0, rnd());
    @(negedge clk);
    sample();
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++)
      cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), rnd(), 0, 0, 0);
    cycle(0, 1, 0, rnd(), 0, 0, 0);
    cycle(0, 1, 0, rnd(), 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
